// File: rtl/mem_pkg.sv
// Shared definitions for the one-hot-addressed 8x16 memory and its clients.
package mem_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_CLEAR,
    ST_DONE
  } state_t;
endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; drives the memory addr<i> selects.
module onehot_dec import mem_pkg::*; #(
  parameter int IDX_W = ADDR_W,
  parameter int OUT_W = DEPTH
) (
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  output logic [OUT_W-1:0] o_onehot
);

  // Compare per bit so an index beyond OUT_W simply yields all-zero.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      o_onehot[i] = i_en && (i_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Scans a wrapping address range of the one-hot memory and streams the words out.
// Define MEM_STREAM_READER_CLEAR_EN to zero each word after it is handed off.
module mem_stream_reader #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int DEPTH  = mem_pkg::DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(DEPTH)-1:0]     first_addr,
  input  logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         done,
  output logic [DEPTH-1:0]             mem_sel,
  output logic                         mem_wen,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_qout,
  output logic [DATA_W-1:0]            m_data,
  output logic [$clog2(DEPTH)-1:0]     m_addr,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready
);
  import mem_pkg::*;

  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH+1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH-1);
  localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(DEPTH);
  localparam logic [1:0]           WAIT_LAST = 2'(RD_LAT-1);

  state_t                r_state, w_state_n;
  logic [ADDR_BITS-1:0]  r_addr, w_addr_n, w_addr_inc;
  logic [CNT_W-1:0]      r_rem, w_rem_n;
  logic [1:0]            r_wait, w_wait_n;
  logic                  r_busy, r_done, r_mlast, w_mlast_n, r_mvalid, w_mvalid_n;
  logic [DEPTH-1:0]      r_sel, w_sel_n;
  logic                  w_sel_en;
  logic [DATA_W-1:0]     r_mdata, w_mdata_n;
  logic [ADDR_BITS-1:0]  r_maddr, w_maddr_n;

  assign w_addr_inc = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_BITS'(1);

  always_comb begin
    w_state_n  = r_state;
    w_addr_n   = r_addr;
    w_rem_n    = r_rem;
    w_wait_n   = r_wait;
    w_mdata_n  = r_mdata;
    w_maddr_n  = r_maddr;
    w_mlast_n  = r_mlast;
    w_mvalid_n = r_mvalid;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_addr_n  = first_addr;
          w_rem_n   = (count > MAX_CNT) ? MAX_CNT : count;
          w_state_n = (count == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_wait_n  = '0;
        w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait == WAIT_LAST) begin
          w_mdata_n  = mem_qout;
          w_maddr_n  = r_addr;
          w_mlast_n  = (r_rem == CNT_W'(1));
          w_mvalid_n = 1'b1;
          w_state_n  = ST_OUT;
        end else begin
          w_wait_n = r_wait + 2'd1;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          w_mvalid_n = 1'b0;
`ifdef MEM_STREAM_READER_CLEAR_EN
          // Address stays put so CLEAR writes the word just delivered.
          w_state_n  = ST_CLEAR;
`else
          w_addr_n   = w_addr_inc;
          w_rem_n    = r_rem - CNT_W'(1);
          w_state_n  = (r_rem == CNT_W'(1)) ? ST_DONE : ST_ISSUE;
`endif
        end
      end
      ST_CLEAR: begin
        w_addr_n  = w_addr_inc;
        w_rem_n   = r_rem - CNT_W'(1);
        w_state_n = (r_rem == CNT_W'(1)) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // Selects are computed from the next state so the registered copy lines up with it.
  assign w_sel_en = (w_state_n == ST_ISSUE) || (w_state_n == ST_WAIT) ||
                    (w_state_n == ST_CLEAR);

  onehot_dec #(
    .IDX_W (ADDR_BITS),
    .OUT_W (DEPTH)
  ) u_dec (
    .i_en     (w_sel_en),
    .i_idx    (w_addr_n),
    .o_onehot (w_sel_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_rem    <= '0;
      r_wait   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sel    <= '0;
      r_mdata  <= '0;
      r_maddr  <= '0;
      r_mlast  <= 1'b0;
      r_mvalid <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_addr   <= w_addr_n;
      r_rem    <= w_rem_n;
      r_wait   <= w_wait_n;
      r_busy   <= (w_state_n != ST_IDLE);
      r_done   <= (w_state_n == ST_DONE);
      r_sel    <= w_sel_n;
      r_mdata  <= w_mdata_n;
      r_maddr  <= w_maddr_n;
      r_mlast  <= w_mlast_n;
      r_mvalid <= w_mvalid_n;
    end
  end

`ifdef MEM_STREAM_READER_CLEAR_EN
  logic r_wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen <= 1'b0;
    end else begin
      r_wen <= (w_state_n == ST_CLEAR);
    end
  end

  assign mem_wen = r_wen;
`else
  assign mem_wen = 1'b0;
`endif

  assign mem_wdata = '0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_sel   = r_sel;
  assign m_data    = r_mdata;
  assign m_addr    = r_maddr;
  assign m_last    = r_mlast;
  assign m_valid   = r_mvalid;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader against a one-hot memory model (RD_LAT = 1).
// Covers the MEM_STREAM_READER_CLEAR_EN build as well when that macro is defined.
module tb_mem_stream_reader;

`ifdef MEM_STREAM_READER_CLEAR_EN
  localparam int PERIOD = 4;
`else
  localparam int PERIOD = 3;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  addr;
    logic        last;
  } expT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  firstAddr = '0;
  logic [3:0]  count = '0;
  logic        busy, done, mem_wen, m_last, m_valid;
  logic [7:0]  mem_sel;
  logic [15:0] mem_wdata, m_data;
  logic [15:0] memQout = '0;
  logic [2:0]  m_addr;
  logic        m_ready = 1'b1;
  logic        memLoad = 1'b0;
  logic [15:0] memArr [8];

  expT sbQ[$];
  int  hsCycles[$];
  int  checks = 0;
  int  errors = 0;
  int  cycleCnt = 0;
  int  hsCount = 0;
  int  doneCount = 0;
  int  selSeen = 0;
  int  wenSeen = 0;

  logic        prevStall = 1'b0;
  logic [15:0] heldData;
  logic [2:0]  heldAddr;
  logic        heldLast;

  mem_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_addr (firstAddr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .mem_sel    (mem_sel),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_qout   (memQout),
    .m_data     (m_data),
    .m_addr     (m_addr),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Memory model: select sampled on the edge, registered read one edge later.
  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 8; i++) memArr[i] <= 16'(16'h0100 + i);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (mem_sel[i]) begin
          if (mem_wen) memArr[i] <= mem_wdata;
          memQout <= memArr[i];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and polices stalls and selects.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_sel != 8'h00) begin
        selSeen++;
        check("sel onehot", 32'($countones(mem_sel)), 32'd1);
      end
      if (mem_wen) wenSeen++;
      if (done) doneCount++;
      if (m_valid && prevStall) begin
        check("stall data", 32'(m_data), 32'(heldData));
        check("stall addr", 32'(m_addr), 32'(heldAddr));
        check("stall last", 32'(m_last), 32'(heldLast));
      end
      if (m_valid && !m_ready) check("stall sel", 32'(mem_sel), 32'd0);
      if (m_valid && m_ready) begin
        hsCount++;
        hsCycles.push_back(cycleCnt);
        if (sbQ.size() == 0) begin
          check("unexpected word", 32'(m_addr), 32'hFFFF_FFFF);
        end else begin
          expT e;
          e = sbQ.pop_front();
          check("m_data", 32'(m_data), 32'(e.data));
          check("m_addr", 32'(m_addr), 32'(e.addr));
          check("m_last", 32'(m_last), 32'(e.last));
        end
      end
      prevStall = m_valid && !m_ready;
      heldData  = m_data;
      heldAddr  = m_addr;
      heldLast  = m_last;
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reloadMem();
    memLoad = 1'b1;
    tick();
    memLoad = 1'b0;
  endtask

  task automatic pushScan(input int fa, input int cnt);
    int n;
    n = (cnt > 8) ? 8 : cnt;
    for (int k = 0; k < n; k++) begin
      expT e;
      int a;
      a = (fa + k) % 8;
      e.data = 16'(16'h0100 + a);
      e.addr = 3'(a);
      e.last = (k == n - 1);
      sbQ.push_back(e);
    end
  endtask

  // Pulses start for one edge; returns just after that edge (E0 + 1).
  task automatic applyStimulus(input int fa, input int cnt);
    firstAddr = 3'(fa);
    count     = 4'(cnt);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic waitDone(input string name, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " busy"},    32'(busy),      32'd0);
    check({tag, " done"},    32'(done),      32'd0);
    check({tag, " sel"},     32'(mem_sel),   32'd0);
    check({tag, " wen"},     32'(mem_wen),   32'd0);
    check({tag, " wdata"},   32'(mem_wdata), 32'd0);
    check({tag, " m_data"},  32'(m_data),    32'd0);
    check({tag, " m_addr"},  32'(m_addr),    32'd0);
    check({tag, " m_last"},  32'(m_last),    32'd0);
    check({tag, " m_valid"}, 32'(m_valid),   32'd0);
  endtask

  initial begin
    int base, doneBefore, selBefore, n;
    expT e;

    reloadMem();
    tick();
    tick();
    checkOutput("reset");
    rst_n = 1'b1;
    tick();

    // Full scan from 0: latency, data, one done, fixed period.
    hsCycles.delete();
    doneBefore = doneCount;
    pushScan(0, 8);
    applyStimulus(0, 8);
    check("sel after start", 32'(mem_sel), 32'h01);
    check("busy after start", 32'(busy), 32'd1);
    tick();
    check("valid at E1", 32'(m_valid), 32'd0);
    tick();
    check("valid at E2", 32'(m_valid), 32'd1);
    waitDone("scan0 done", 200);
    tick();
    check("scan0 done pulses", 32'(doneCount - doneBefore), 32'd1);
    check("scan0 busy low", 32'(busy), 32'd0);
    check("scan0 queue empty", 32'(sbQ.size()), 32'd0);
    check("scan0 words", 32'(hsCycles.size()), 32'd8);
    for (int i = 1; i < hsCycles.size(); i++)
      check("scan0 period", 32'(hsCycles[i] - hsCycles[i-1]), 32'(PERIOD));

    // Wrapping range.
    reloadMem();
    pushScan(6, 4);
    applyStimulus(6, 4);
    check("wrap sel", 32'(mem_sel), 32'h40);
    waitDone("wrap done", 200);
    tick();
    check("wrap queue empty", 32'(sbQ.size()), 32'd0);

    // count = 0: immediate done, no memory access, no words.
    base = hsCount;
    selBefore = selSeen;
    applyStimulus(3, 0);
    check("zero done", 32'(done), 32'd1);
    check("zero busy", 32'(busy), 32'd1);
    check("zero sel", 32'(mem_sel), 32'd0);
    tick();
    check("zero done drop", 32'(done), 32'd0);
    check("zero busy drop", 32'(busy), 32'd0);
    tick();
    tick();
    check("zero no words", 32'(hsCount - base), 32'd0);
    check("zero no sel", 32'(selSeen - selBefore), 32'd0);

    // count = 12 saturates to 8 words.
    reloadMem();
    base = hsCount;
    pushScan(3, 12);
    applyStimulus(3, 12);
    waitDone("sat done", 300);
    repeat (6) tick();
    check("sat words", 32'(hsCount - base), 32'd8);
    check("sat queue empty", 32'(sbQ.size()), 32'd0);

    // Consumer stalls five cycles on word 2.
    reloadMem();
    base = hsCount;
    pushScan(0, 4);
    applyStimulus(0, 4);
    n = 0;
    while (mem_sel !== 8'h04 && n < 50) begin tick(); n++; end
    check("stall reach word2", 32'(mem_sel), 32'h04);
    m_ready = 1'b0;
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin tick(); n++; end
    check("stall valid", 32'(m_valid), 32'd1);
    repeat (5) tick();
    check("stall still valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    waitDone("stall done", 200);
    tick();
    check("stall words", 32'(hsCount - base), 32'd4);
    check("stall queue empty", 32'(sbQ.size()), 32'd0);

    // Asynchronous reset after word 3, then a fresh scan with an ignored start.
    reloadMem();
    base = hsCount;
    pushScan(0, 8);
    applyStimulus(0, 8);
    n = 0;
    while (hsCount - base < 3 && n < 100) begin tick(); n++; end
    check("abort reach word3", 32'(hsCount - base), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort");
    sbQ.delete();
    doneBefore = doneCount;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("abort no done", 32'(doneCount - doneBefore), 32'd0);
    check("abort idle", 32'(busy), 32'd0);
    base = hsCount;
    pushScan(5, 3);
    applyStimulus(5, 3);
    check("restart sel", 32'(mem_sel), 32'h20);
    tick();
    applyStimulus(0, 2);
    waitDone("restart done", 200);
    repeat (8) tick();
    check("restart words", 32'(hsCount - base), 32'd3);
    check("restart one done", 32'(doneCount - doneBefore), 32'd1);
    check("restart queue empty", 32'(sbQ.size()), 32'd0);

`ifdef MEM_STREAM_READER_CLEAR_EN
    // Clear-on-read: words 2 and 3 become zero, the rest are untouched.
    reloadMem();
    pushScan(2, 2);
    applyStimulus(2, 2);
    waitDone("clear done", 200);
    tick();
    for (int a = 0; a < 8; a++) begin
      e.data = (a == 2 || a == 3) ? 16'h0000 : 16'(16'h0100 + a);
      e.addr = 3'(a);
      e.last = (a == 7);
      sbQ.push_back(e);
    end
    applyStimulus(0, 8);
    waitDone("readback done", 300);
    tick();
    check("readback queue empty", 32'(sbQ.size()), 32'd0);
    check("clear wen used", 32'(wenSeen > 0), 32'd1);
`else
    e = '0;
    check("wen never", 32'(wenSeen), 32'd0);
    check("scratch", 32'(e), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
